// File: rtl/hier_icache_bank_cmd_seq.sv
// Maintenance-command sequencer for the shared L1.5 icache banks: raises per-bank
// level requests for one command at a time and reports completion or timeout.
module hier_icache_bank_cmd_seq #(
    parameter int NB_BANKS  = 4,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [NB_BANKS-1:0]  cmd_mask_i,
    input  logic [ADDR_W-1:0]    cmd_addr_i,
    input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
    output logic                 busy_o,
    output logic                 done_valid_o,
    output logic                 done_err_o,
    output logic [NB_BANKS-1:0]  done_err_mask_o,
    output logic [NB_BANKS-1:0]  enable_req_o,
    input  logic [NB_BANKS-1:0]  enable_ack_i,
    output logic [NB_BANKS-1:0]  disable_req_o,
    input  logic [NB_BANKS-1:0]  disable_ack_i,
    output logic [NB_BANKS-1:0]  flush_req_o,
    input  logic [NB_BANKS-1:0]  flush_ack_i,
    output logic [NB_BANKS-1:0]  sel_flush_req_o,
    output logic [ADDR_W-1:0]    sel_flush_addr_o,
    input  logic [NB_BANKS-1:0]  sel_flush_ack_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [1:0]                 r_op;
    logic [NB_BANKS-1:0]        r_pending;
    logic [NB_BANKS-1:0]        r_err_mask;
    logic [TIMEOUT_W-1:0]       r_count;
    logic [ADDR_W-1:0]          r_addr;
    logic                       r_busy;
    logic                       r_done_valid;
    logic                       r_done_err;
    logic [3:0][NB_BANKS-1:0]   r_req;

    logic [3:0][NB_BANKS-1:0]   w_ack_bus;
    logic [NB_BANKS-1:0]        w_ack_sel;
    logic [NB_BANKS-1:0]        w_remaining;
    logic [NB_BANKS-1:0]        w_pending_next;
    logic [TIMEOUT_W:0]         w_count_inc;
    logic                       w_timeout;
    logic                       w_accept;

    // Bus index follows the op encoding: 0 enable, 1 disable, 2 flush, 3 sel_flush.
    assign w_ack_bus      = {sel_flush_ack_i, flush_ack_i, disable_ack_i, enable_ack_i};
    assign w_ack_sel      = w_ack_bus[r_op];
    assign w_remaining    = r_pending & ~w_ack_sel;
    assign w_count_inc    = {1'b0, r_count} + {{TIMEOUT_W{1'b0}}, 1'b1};
    // Success takes priority: a timeout only counts while banks are still outstanding.
    assign w_timeout      = (timeout_cycles_i != '0)
                          && (w_count_inc == {1'b0, timeout_cycles_i})
                          && (w_remaining != '0);
    assign w_pending_next = w_timeout ? '0 : w_remaining;

    assign cmd_ready_o      = (r_state == S_IDLE) && !rst_i;
    assign w_accept         = cmd_valid_i && cmd_ready_o;
    assign busy_o           = r_busy;
    assign done_valid_o     = r_done_valid;
    assign done_err_o       = r_done_err;
    assign done_err_mask_o  = r_err_mask;
    assign enable_req_o     = r_req[0];
    assign disable_req_o    = r_req[1];
    assign flush_req_o      = r_req[2];
    assign sel_flush_req_o  = r_req[3];
    assign sel_flush_addr_o = r_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_op         <= 2'd0;
            r_pending    <= '0;
            r_err_mask   <= '0;
            r_count      <= '0;
            r_addr       <= '0;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
            r_done_err   <= 1'b0;
            r_req        <= '0;
        end else begin
            r_done_valid <= 1'b0;
            r_done_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op            <= cmd_op_i;
                        r_addr          <= cmd_addr_i;
                        r_pending       <= cmd_mask_i;
                        r_count         <= '0;
                        r_err_mask      <= '0;
                        r_req           <= '0;
                        r_req[cmd_op_i] <= cmd_mask_i;
                        r_busy          <= 1'b1;
                        if (cmd_mask_i != '0) begin
                            r_state <= S_WAIT;
                        end else begin
                            r_state      <= S_DONE;
                            r_done_valid <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    r_pending   <= w_pending_next;
                    r_count     <= (r_count == '1) ? r_count : w_count_inc[TIMEOUT_W-1:0];
                    r_req       <= '0;
                    r_req[r_op] <= w_pending_next;
                    if (w_remaining == '0) begin
                        r_state      <= S_DONE;
                        r_done_valid <= 1'b1;
                    end else if (w_timeout) begin
                        r_state      <= S_DONE;
                        r_done_valid <= 1'b1;
                        r_done_err   <= 1'b1;
                        r_err_mask   <= w_remaining;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hier_icache_bank_cmd_seq.sv
// Bench for hier_icache_bank_cmd_seq: directed vector table, reset corner case and
// randomized commands checked cycle by cycle against a per-bank timing model.
module tb_hier_icache_bank_cmd_seq;

    localparam int NB    = 4;
    localparam int AW    = 32;
    localparam int TW    = 16;
    localparam int NEVER = 1000;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [NB-1:0] cmd_mask_i;
    logic [AW-1:0] cmd_addr_i;
    logic [TW-1:0] timeout_cycles_i;
    logic          busy_o;
    logic          done_valid_o;
    logic          done_err_o;
    logic [NB-1:0] done_err_mask_o;
    logic [NB-1:0] enable_req_o, enable_ack_i;
    logic [NB-1:0] disable_req_o, disable_ack_i;
    logic [NB-1:0] flush_req_o, flush_ack_i;
    logic [NB-1:0] sel_flush_req_o, sel_flush_ack_i;
    logic [AW-1:0] sel_flush_addr_o;

    int n_pass  = 0;
    int n_total = 0;

    hier_icache_bank_cmd_seq #(.NB_BANKS(NB), .ADDR_W(AW), .TIMEOUT_W(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_mask_i(cmd_mask_i), .cmd_addr_i(cmd_addr_i),
        .timeout_cycles_i(timeout_cycles_i),
        .busy_o(busy_o), .done_valid_o(done_valid_o), .done_err_o(done_err_o),
        .done_err_mask_o(done_err_mask_o),
        .enable_req_o(enable_req_o), .enable_ack_i(enable_ack_i),
        .disable_req_o(disable_req_o), .disable_ack_i(disable_ack_i),
        .flush_req_o(flush_req_o), .flush_ack_i(flush_ack_i),
        .sel_flush_req_o(sel_flush_req_o), .sel_flush_addr_o(sel_flush_addr_o),
        .sel_flush_ack_i(sel_flush_ack_i)
    );

    always #5 clk_i = ~clk_i;

    // One command: ack cycle per bank (cycle index relative to accept = cycle 0),
    // timeout value, optional live change of timeout from cycle chg_at onward.
    typedef struct {
        logic [1:0]       op;
        logic [3:0]       mask;
        logic [31:0]      addr;
        logic [3:0][11:0] acks;
        int               tmo;
        int               tmo2;
        int               chg_at;
        int               exp_done;
        logic             exp_err;
        logic [3:0]       exp_emask;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [3:0] mask, input logic [31:0] addr,
                                input int a0, input int a1, input int a2, input int a3,
                                input int tmo, input int tmo2, input int chg_at,
                                input int ed, input logic ee, input logic [3:0] em);
        vec_t v;
        v.op = op; v.mask = mask; v.addr = addr;
        v.acks[0] = a0[11:0]; v.acks[1] = a1[11:0]; v.acks[2] = a2[11:0]; v.acks[3] = a3[11:0];
        v.tmo = tmo; v.tmo2 = tmo2; v.chg_at = chg_at;
        v.exp_done = ed; v.exp_err = ee; v.exp_emask = em;
        return v;
    endfunction

    function automatic int tmo_at(input vec_t v, input int t);
        return (v.chg_at != 0 && t >= v.chg_at) ? v.tmo2 : v.tmo;
    endfunction

    // Reference: a bank is outstanding in cycle t while its ack cycle is later than t.
    // Completion is reported the cycle after everything is acked or the limit is hit.
    function automatic void model(input vec_t v, output int done_t, output logic err, output logic [3:0] emask);
        logic [3:0] rem;
        done_t = 1; err = 1'b0; emask = '0;
        if (v.mask == 4'd0) return;
        for (int t = 1; t < 200; t++) begin
            rem = '0;
            for (int b = 0; b < NB; b++)
                if (v.mask[b] && int'(v.acks[b]) > t) rem[b] = 1'b1;
            if (rem == 4'd0) begin
                done_t = t + 1;
                return;
            end
            if (tmo_at(v, t) != 0 && t == tmo_at(v, t)) begin
                done_t = t + 1; err = 1'b1; emask = rem;
                return;
            end
        end
        done_t = 200;
    endfunction

    task automatic drive_acks(input vec_t v, input int t);
        logic [3:0][3:0] bus;
        bus = $urandom;
        for (int b = 0; b < NB; b++)
            if (v.mask[b]) bus[v.op][b] = (int'(v.acks[b]) == t);
        enable_ack_i = bus[0]; disable_ack_i = bus[1]; flush_ack_i = bus[2]; sel_flush_ack_i = bus[3];
    endtask

    task automatic run_cmd(input vec_t v, input int done_t, input logic err, input logic [3:0] emask,
                           input string tag);
        logic [15:0] exp_req, act_req;
        @(negedge clk_i);
        chk("ready_before_accept", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_op_i = v.op; cmd_mask_i = v.mask; cmd_addr_i = v.addr;
        timeout_cycles_i = TW'(tmo_at(v, 0));
        drive_acks(v, 0);
        for (int t = 1; t <= done_t + 1; t++) begin
            @(negedge clk_i);
            exp_req = '0;
            for (int b = 0; b < NB; b++)
                if (v.mask[b] && t <= int'(v.acks[b]) && t < done_t) exp_req[v.op*4+b] = 1'b1;
            act_req = {sel_flush_req_o, flush_req_o, disable_req_o, enable_req_o};
            chk("req", act_req, exp_req);
            chk("sel_addr", sel_flush_addr_o, v.addr);
            chk("busy", busy_o, t <= done_t);
            chk("done_valid", done_valid_o, t == done_t);
            chk("done_err", done_err_o, (t == done_t) ? err : 1'b0);
            chk("err_mask", done_err_mask_o, (t >= done_t) ? emask : 4'd0);
            chk("ready", cmd_ready_o, t > done_t);
            // Random requests while busy must be ignored; none on the cycle the bench checks idle.
            cmd_valid_i = (t <= done_t) ? 1'($urandom) : 1'b0;
            cmd_op_i = 2'($urandom); cmd_mask_i = 4'($urandom); cmd_addr_i = $urandom;
            timeout_cycles_i = TW'(tmo_at(v, t));
            drive_acks(v, t);
        end
        $display("txn %s op=%0d mask=%b tmo=%0d done_cycle=%0d err=%0b err_mask=%b",
                 tag, v.op, v.mask, v.tmo, done_t, err, emask);
    endtask

    initial begin
        vec_t v;
        int   d;
        logic e;
        logic [3:0] m;

        tbl[0] = mk(2'd2, 4'b1111, 32'h0,          2, 2, 2, 2,             0, 0, 0, 3, 1'b0, 4'b0000);
        tbl[1] = mk(2'd0, 4'b0101, 32'h0,          3, NEVER, 6, NEVER,     0, 0, 0, 7, 1'b0, 4'b0000);
        tbl[2] = mk(2'd3, 4'b0010, 32'h1C00_0040,  NEVER, 4, NEVER, NEVER, 0, 0, 0, 5, 1'b0, 4'b0000);
        tbl[3] = mk(2'd1, 4'b1111, 32'h0,          2, 3, 4, NEVER,         8, 0, 0, 9, 1'b1, 4'b1000);
        tbl[4] = mk(2'd2, 4'b0000, 32'h55,         1, 1, 1, 1,             0, 0, 0, 1, 1'b0, 4'b0000);
        tbl[5] = mk(2'd2, 4'b0011, 32'h0,          2, 5, NEVER, NEVER,     5, 0, 0, 6, 1'b0, 4'b0000);
        tbl[6] = mk(2'd3, 4'b1100, 32'hA,          NEVER, NEVER, NEVER, 3, 4, 0, 0, 5, 1'b1, 4'b0100);
        tbl[7] = mk(2'd2, 4'b0001, 32'h0,          NEVER, 1, 1, 1,         0, 6, 5, 7, 1'b1, 4'b0001);
        tbl[8] = mk(2'd0, 4'b0011, 32'h0,          1, 2, NEVER, NEVER,     1, 0, 0, 2, 1'b1, 4'b0010);

        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_mask_i = '0; cmd_addr_i = '0;
        timeout_cycles_i = '0;
        enable_ack_i = '0; disable_ack_i = '0; flush_ack_i = '0; sel_flush_ack_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", cmd_ready_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", {done_valid_o, done_err_o, done_err_mask_o}, 0);
        chk("rst_req", {sel_flush_req_o, flush_req_o, disable_req_o, enable_req_o}, 0);
        chk("rst_addr", sel_flush_addr_o, 0);
        rst_i = 1'b0;

        foreach (tbl[i]) run_cmd(tbl[i], tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_emask, $sformatf("vec%0d", i));

        // Reset in the middle of a wait: requests drop, no completion strobe.
        @(negedge clk_i);
        cmd_valid_i = 1'b1; cmd_op_i = 2'd2; cmd_mask_i = 4'b1111; timeout_cycles_i = '0;
        enable_ack_i = '0; disable_ack_i = '0; flush_ack_i = '0; sel_flush_ack_i = '0;
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        chk("mid_req_up", flush_req_o, 4'b1111);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("mid_ready_in_rst", cmd_ready_o, 0);
        @(negedge clk_i);
        chk("mid_req_down", {sel_flush_req_o, flush_req_o, disable_req_o, enable_req_o}, 0);
        chk("mid_busy", busy_o, 0);
        chk("mid_no_done", done_valid_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_no_done", done_valid_o, 0);
        $display("txn reset_mid_wait");
        run_cmd(tbl[0], tbl[0].exp_done, tbl[0].exp_err, tbl[0].exp_emask, "after_reset");

        for (int n = 0; n < 40; n++) begin
            v = mk(2'($urandom_range(0, 3)), 4'($urandom), $urandom, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 4'b0);
            for (int b = 0; b < NB; b++)
                v.acks[b] = ($urandom_range(0, 4) == 0) ? 12'(NEVER) : 12'($urandom_range(1, 10));
            v.tmo = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 10);
            for (int b = 0; b < NB; b++)
                if (v.tmo == 0 && v.mask[b] && int'(v.acks[b]) == NEVER) v.tmo = $urandom_range(1, 10);
            model(v, d, e, m);
            run_cmd(v, d, e, m, $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
